// File: rtl/vector_stream_ram.sv
// Image vector store with a burst read streamer.
// One command streams every segment of one image over valid/ready; a 2-entry
// output skid FIFO absorbs the 1-cycle RAM latency and downstream backpressure.
module vector_stream_ram #(
    parameter int unsigned DATA_W       = 1024,
    parameter int unsigned SEGS_PER_IMG = 8,
    parameter int unsigned NUM_IMGS     = 10,
    parameter int unsigned ADDR_W       = 7,
    parameter int unsigned IMG_W        = 4,
    parameter int unsigned SEG_W        = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IMG_W-1:0]  cmd_img,
    output logic              cmd_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [SEG_W-1:0]  out_seg,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned      NUM_ROWS = NUM_IMGS * SEGS_PER_IMG;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(SEGS_PER_IMG - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEG_W-1:0]  seg;
        logic              last;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    logic [DATA_W-1:0] mem [NUM_ROWS];
    logic [DATA_W-1:0] ram_q;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base, base_n;
    logic [SEG_W-1:0]  rd_cnt, rd_cnt_n;
    logic              busy_n, cmd_ready_n, cmd_err_n;

    logic              rd_en_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [SEG_W-1:0]  rd_seg_c;
    logic              rd_vld;
    logic [SEG_W-1:0]  rd_seg;

    logic [1:0]        cnt, cnt_n;
    beat_t             head, head_n, skid, skid_n, new_beat_c;
    logic              out_valid_n;

    logic              pop_c, accept_c, img_ok_c, wr_ok_c, credit_ok_c;
    logic [2:0]        committed_c;

    assign pop_c       = out_valid & out_ready;
    assign accept_c    = cmd_valid & cmd_ready;
    assign img_ok_c    = {1'b0, cmd_img} < (IMG_W + 1)'(NUM_IMGS);
    assign wr_ok_c     = {1'b0, wr_addr} < (ADDR_W + 1)'(NUM_ROWS);
    // Entries buffered plus the read in flight, net of the beat leaving this cycle.
    assign committed_c = 3'(cnt) + 3'(rd_vld) - 3'(pop_c);
    assign credit_ok_c = committed_c < 3'd2;

    // Read-first RAM: the read samples the array before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (write_enable && wr_ok_c) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en_c) begin
            ram_q <= mem[rd_addr_c];
        end
    end

    // Command FSM: segment 0 is read in the accept cycle so the first beat lands at T+2.
    always_comb begin
        state_n     = state;
        base_n      = base;
        rd_cnt_n    = rd_cnt;
        busy_n      = busy;
        cmd_err_n   = 1'b0;
        rd_en_c     = 1'b0;
        rd_addr_c   = base + ADDR_W'(rd_cnt);
        rd_seg_c    = rd_cnt;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (img_ok_c) begin
                        base_n    = ADDR_W'(cmd_img) * ADDR_W'(SEGS_PER_IMG);
                        rd_en_c   = 1'b1;
                        rd_addr_c = base_n;
                        rd_seg_c  = '0;
                        rd_cnt_n  = SEG_W'(1);
                        busy_n    = 1'b1;
                        state_n   = (SEGS_PER_IMG == 1) ? DRAIN : STREAM;
                    end else begin
                        cmd_err_n = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (credit_ok_c) begin
                    rd_en_c = 1'b1;
                    if (rd_cnt == LAST_SEG) begin
                        state_n = DRAIN;
                    end else begin
                        rd_cnt_n = rd_cnt + SEG_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (pop_c && head.last) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        cmd_ready_n = (state_n == IDLE);
    end

    // FSM and read-pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            rd_cnt    <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            cmd_err   <= 1'b0;
            rd_vld    <= 1'b0;
            rd_seg    <= '0;
        end else begin
            state     <= state_n;
            base      <= base_n;
            rd_cnt    <= rd_cnt_n;
            busy      <= busy_n;
            cmd_ready <= cmd_ready_n;
            cmd_err   <= cmd_err_n;
            rd_vld    <= rd_en_c;
            rd_seg    <= rd_seg_c;
        end
    end

    // Skid FIFO next state: head is the output register, skid holds the second beat.
    always_comb begin
        cnt_n           = cnt;
        head_n          = head;
        skid_n          = skid;
        new_beat_c.data = ram_q;
        new_beat_c.seg  = rd_seg;
        new_beat_c.last = (rd_seg == LAST_SEG);
        case (cnt)
            2'd0: begin
                if (rd_vld) begin
                    head_n = new_beat_c;
                    cnt_n  = 2'd1;
                end
            end
            2'd1: begin
                if (pop_c && rd_vld) begin
                    head_n = new_beat_c;
                end else if (pop_c) begin
                    cnt_n = 2'd0;
                end else if (rd_vld) begin
                    skid_n = new_beat_c;
                    cnt_n  = 2'd2;
                end
            end
            default: begin
                if (pop_c) begin
                    head_n = skid;
                    if (rd_vld) begin
                        skid_n = new_beat_c;
                    end else begin
                        cnt_n = 2'd1;
                    end
                end
            end
        endcase
        out_valid_n = (cnt_n != 2'd0);
    end

    // Skid FIFO registers; a reset discards any beats in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 2'd0;
            head      <= '0;
            skid      <= '0;
            out_valid <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            head      <= head_n;
            skid      <= skid_n;
            out_valid <= out_valid_n;
        end
    end

    assign out_data = head.data;
    assign out_seg  = head.seg;
    assign out_last = head.last;

endmodule

// File: tb/tb_vector_stream_ram.sv
// Directed bench for vector_stream_ram: latency, backpressure, errors,
// read-first writes, mid-stream reset and back-to-back commands.
module tb_vector_stream_ram;

    localparam int unsigned DATA_W = 1024;
    localparam int unsigned SEGS   = 8;
    localparam int unsigned NIMG   = 10;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned IMG_W  = 4;
    localparam int unsigned SEG_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              write_enable;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [IMG_W-1:0]  cmd_img;
    logic              cmd_err;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEG_W-1:0]  out_seg;
    logic              out_last;
    logic              busy;

    int tests = 0;
    int fails = 0;
    logic [7:0]        lfsr = 8'hA5;
    logic [DATA_W-1:0] exp_row [SEGS];

    vector_stream_ram #(
        .DATA_W(DATA_W), .SEGS_PER_IMG(SEGS), .NUM_IMGS(NIMG),
        .ADDR_W(ADDR_W), .IMG_W(IMG_W), .SEG_W(SEG_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .write_enable(write_enable), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_img(cmd_img), .cmd_err(cmd_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_seg(out_seg), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(input int r);
        logic [7:0] b;
        b = 8'(r);
        return {128{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed[127:0]=%h expected[127:0]=%h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic load_rows(input int first_row);
        for (int i = 0; i < int'(SEGS); i++) exp_row[i] = pat(first_row + i);
    endtask

    task automatic send_cmd(input int img);
        cmd_valid = 1'b1;
        cmd_img   = IMG_W'(img);
        chk("cmd_ready_before", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Consumes one image against exp_row; checks order, stability while stalled and count.
    task automatic consume(input bit stall, output int cycles);
        int got;
        bit prev_stall;
        logic [DATA_W-1:0] p_data;
        logic [SEG_W-1:0]  p_seg;
        got = 0; cycles = 0; prev_stall = 1'b0; p_data = '0; p_seg = '0;
        while (got < int'(SEGS) && cycles < 200) begin
            if (stall) begin
                lfsr      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                out_ready = lfsr[0];
            end else begin
                out_ready = 1'b1;
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 1);
                chkd("hold_data", out_data, p_data);
                chk("hold_seg", 32'(out_seg), 32'(p_seg));
            end
            if (out_valid && out_ready) begin
                chk("beat_seg", 32'(out_seg), got);
                chkd("beat_data", out_data, exp_row[got]);
                chk("beat_last", 32'(out_last), (got == int'(SEGS) - 1) ? 1 : 0);
                got++;
            end
            prev_stall = out_valid && !out_ready;
            p_data     = out_data;
            p_seg      = out_seg;
            tick();
            cycles++;
        end
        chk("beat_count", got, int'(SEGS));
        out_ready = 1'b1;
    endtask

    initial begin
        int cyc;
        int n;
        int acc2;
        int last0;
        bit accepted2;

        rst_n = 1'b0; write_enable = 1'b0; wr_addr = '0; wr_data = '0;
        cmd_valid = 1'b0; cmd_img = '0; out_ready = 1'b1;
        tick(); tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_err", 32'(cmd_err), 0);
        chkd("rst_out_data", out_data, '0);
        rst_n = 1'b1;
        tick();

        // Fill every row with its own index.
        for (int r = 0; r < int'(SEGS * NIMG); r++) begin
            write_enable = 1'b1;
            wr_addr      = ADDR_W'(r);
            wr_data      = pat(r);
            tick();
        end
        write_enable = 1'b0;

        // 1: image 3 with out_ready high, first beat at T+2, 8 consecutive beats.
        load_rows(24);
        send_cmd(3);
        chk("t1_valid_t1", 32'(out_valid), 0);
        chk("t1_busy_t1", 32'(busy), 1);
        chk("t1_ready_t1", 32'(cmd_ready), 0);
        tick();
        chk("t1_valid_t2", 32'(out_valid), 1);
        consume(1'b0, cyc);
        chk("t1_cycles", cyc, 8);
        chk("t1_busy_end", 32'(busy), 0);
        chk("t1_ready_end", 32'(cmd_ready), 1);
        chk("t1_valid_end", 32'(out_valid), 0);

        // 2: same image under pseudo-random backpressure.
        send_cmd(3);
        consume(1'b1, cyc);
        chk("t2_busy_end", 32'(busy), 0);

        // 3: out-of-range image raises a one-cycle error and streams nothing.
        send_cmd(10);
        chk("t3_err_t1", 32'(cmd_err), 1);
        chk("t3_busy_t1", 32'(busy), 0);
        chk("t3_valid_t1", 32'(out_valid), 0);
        tick();
        chk("t3_err_t2", 32'(cmd_err), 0);
        chk("t3_valid_t2", 32'(out_valid), 0);
        chk("t3_ready_t2", 32'(cmd_ready), 1);

        // 4: image 2; row 16 overwritten in its read cycle, row 23 rewritten at T+1.
        load_rows(16);
        exp_row[7] = {128{8'hAB}};
        cmd_valid = 1'b1; cmd_img = IMG_W'(2);
        write_enable = 1'b1; wr_addr = ADDR_W'(16); wr_data = {128{8'h55}};
        tick();
        cmd_valid = 1'b0;
        wr_addr = ADDR_W'(23); wr_data = {128{8'hAB}};
        tick();
        write_enable = 1'b0;
        consume(1'b0, cyc);
        chk("t4_cycles", cyc, 8);

        // 5: reset after beat 3 of image 5, then restart the same image.
        load_rows(40);
        send_cmd(5);
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("t5_pre_seg", 32'(out_seg), 4);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ready", 32'(cmd_ready), 1);
        chk("t5_rst_seg", 32'(out_seg), 0);
        chk("t5_rst_last", 32'(out_last), 0);
        chkd("t5_rst_data", out_data, '0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("t5_idle_valid", 32'(out_valid), 0);
        send_cmd(5);
        tick();
        consume(1'b0, cyc);
        chk("t5_cycles", cyc, 8);

        // 6: back-to-back images 0 and 9 with cmd_valid held.
        cmd_valid = 1'b1; cmd_img = IMG_W'(0);
        tick();
        cmd_img = IMG_W'(9);
        n = 0; cyc = 0; acc2 = -1; last0 = -1; accepted2 = 1'b0;
        while (n < 16 && cyc < 100) begin
            if (cmd_valid && cmd_ready) begin
                acc2 = cyc;
                accepted2 = 1'b1;
            end
            if (out_valid) begin
                chk("t6_seg", 32'(out_seg), n % 8);
                chkd("t6_data", out_data, pat((n < 8) ? n : 64 + n));
                chk("t6_last", 32'(out_last), (n % 8 == 7) ? 1 : 0);
                if (n == 7) last0 = cyc;
                n++;
            end
            tick();
            cyc++;
            if (accepted2) cmd_valid = 1'b0;
        end
        chk("t6_beats", n, 16);
        chk("t6_accept_gap", acc2 - last0, 1);
        chk("t6_busy_end", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
